// File: rtl/mac_pkg.sv
// Shared types and default sizing for the MAC sequencer block.
package mac_pkg;

  // Operand width, command length width, and result width.
  // The result width fits a full 15-pair dot product of max-value operands.
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_LEN_W   = 4;
  localparam int DEF_ACC_W   = 20;
  // Cycles from mac_en to the external datapath's mac_acc reflecting it.
  localparam int DEF_MAC_LAT = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } mac_state_t;

endpackage

// File: rtl/mac_sequencer_if.sv
// Bundle of command, operand, MAC datapath and result signals around the sequencer.
interface mac_sequencer_if #(
  parameter int DATA_W = mac_pkg::DEF_DATA_W,
  parameter int LEN_W  = mac_pkg::DEF_LEN_W,
  parameter int ACC_W  = mac_pkg::DEF_ACC_W
);
  // Handshakes (cmd, op, res): a transfer occurs on a rising clk edge where
  // valid && ready are both high. The source holds valid and its payload until
  // that edge; valid never depends on ready. ready may be high without valid.
  logic              cmd_valid;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len;

  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  logic              mac_clr;
  logic              mac_en;
  logic [DATA_W-1:0] mac_a;
  logic [DATA_W-1:0] mac_b;
  logic [ACC_W-1:0]  mac_acc;

  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;

  logic              busy;
  mac_pkg::mac_state_t state;   // debug view of the sequencer FSM

  // Sequencer side.
  modport master (
    input  cmd_valid, cmd_len, op_valid, op_a, op_b, mac_acc, res_ready,
    output cmd_ready, op_ready, mac_clr, mac_en, mac_a, mac_b,
           res_valid, res_data, busy, state
  );

  // Environment side: command/operand source, MAC datapath, result sink.
  modport slave (
    output cmd_valid, cmd_len, op_valid, op_a, op_b, mac_acc, res_ready,
    input  cmd_ready, op_ready, mac_clr, mac_en, mac_a, mac_b,
           res_valid, res_data, busy, state
  );

endinterface

// File: rtl/mac_drain_timer.sv
// Count-down timer: after a load pulse, done is high in the CYCLES-th cycle.
module mac_drain_timer #(
  parameter int CYCLES = mac_pkg::DEF_MAC_LAT + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);
  localparam int CNT_W = $clog2(CYCLES + 1);

  logic [CNT_W-1:0] count;

  // Load the full wait on entry, then count down to zero and stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(CYCLES);
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  // The count reaches one in the last waiting cycle.
  assign done = (count == CNT_W'(1));

endmodule

// File: rtl/mac_sequencer.sv
// Dot-product sequencer: accepts a length command, streams operand pairs into
// an external pipelined MAC datapath, waits for it to drain, returns the sum.
module mac_sequencer #(
  parameter int DATA_W  = mac_pkg::DEF_DATA_W,
  parameter int LEN_W   = mac_pkg::DEF_LEN_W,
  parameter int ACC_W   = mac_pkg::DEF_ACC_W,
  parameter int MAC_LAT = mac_pkg::DEF_MAC_LAT
) (
  input  logic           clk,
  input  logic           rst,
  mac_sequencer_if.master bus
);
  import mac_pkg::*;

  mac_state_t        state;
  logic [LEN_W-1:0]  remaining;
  logic              mac_clr_q;
  logic              mac_en_q;
  logic [DATA_W-1:0] mac_a_q;
  logic [DATA_W-1:0] mac_b_q;
  logic              res_valid_q;
  logic [ACC_W-1:0]  res_data_q;

  logic              op_fire;
  logic              last_pair;
  logic              drain_done;

  assign op_fire   = (state == S_LOAD) && bus.op_valid;
  assign last_pair = op_fire && (remaining == LEN_W'(1));

  // Started by the last accepted pair, so the wait is counted from DRAIN entry.
  mac_drain_timer #(
    .CYCLES (MAC_LAT + 1)
  ) u_drain_timer (
    .clk  (clk),
    .rst  (rst),
    .load (last_pair),
    .done (drain_done)
  );

  // Sequencer FSM with registered datapath controls and result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      remaining   <= '0;
      mac_clr_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      // Single-cycle strobes.
      mac_clr_q <= 1'b0;
      mac_en_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            remaining <= bus.cmd_len;
            if (bus.cmd_len != '0) begin
              state     <= S_LOAD;
              mac_clr_q <= 1'b1;
            end else begin
              // Empty product: answer zero without touching the datapath.
              state       <= S_DONE;
              res_data_q  <= '0;
              res_valid_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (op_fire) begin
            mac_en_q  <= 1'b1;
            mac_a_q   <= bus.op_a;
            mac_b_q   <= bus.op_b;
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (drain_done) begin
            res_data_q  <= bus.mac_acc;
            res_valid_q <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Ready/busy are decoded from the state register only.
  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.op_ready  = (state == S_LOAD);
  assign bus.busy      = (state != S_IDLE);
  assign bus.state     = state;

  assign bus.mac_clr   = mac_clr_q;
  assign bus.mac_en    = mac_en_q;
  assign bus.mac_a     = mac_a_q;
  assign bus.mac_b     = mac_b_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: vector table, corner sequences, random commands.
module tb_mac_sequencer;
  localparam int DW  = mac_pkg::DEF_DATA_W;
  localparam int LW  = mac_pkg::DEF_LEN_W;
  localparam int AW  = mac_pkg::DEF_ACC_W;
  localparam int LAT = mac_pkg::DEF_MAC_LAT;

  logic clk;
  logic rst;

  mac_sequencer_if #(.DATA_W(DW), .LEN_W(LW), .ACC_W(AW)) bus ();

  mac_sequencer #(
    .DATA_W  (DW),
    .LEN_W   (LW),
    .ACC_W   (AW),
    .MAC_LAT (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int clr_cnt = 0;
  logic [AW-1:0] exp_q[$];
  logic [DW-1:0] pa[$];
  logic [DW-1:0] pb[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- MAC datapath model ----------------
  // Each cycle's {clr, en, a*b} lands in the accumulator MAC_LAT cycles later.
  typedef struct packed {
    logic          clr;
    logic          en;
    logic [2*DW-1:0] prod;
  } mac_op_t;

  mac_op_t       pipe_q[$];
  logic [AW-1:0] model_acc;

  always @(posedge clk or posedge rst) begin : mac_model
    mac_op_t cur;
    mac_op_t head;
    if (rst) begin
      pipe_q.delete();
      model_acc <= '0;
    end else begin
      cur.clr  = bus.mac_clr;
      cur.en   = bus.mac_en;
      cur.prod = (2*DW)'(bus.mac_a) * (2*DW)'(bus.mac_b);
      pipe_q.push_back(cur);
      if (pipe_q.size() >= LAT) begin
        head = pipe_q.pop_front();
        if (head.clr) model_acc <= '0;
        else if (head.en) model_acc <= model_acc + AW'(head.prod);
      end
    end
  end

  assign bus.mac_acc = model_acc;

  // Pulse counters, sampled at the active edge.
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.mac_en) en_cnt++;
      if (bus.mac_clr) clr_cnt++;
    end
  end

  // Cycle invariants.
  always @(negedge clk) begin
    if (!rst) begin
      check("inv_clr_and_en", int'(bus.mac_clr && bus.mac_en), 0);
      check("inv_cmd_and_op_ready", int'(bus.cmd_ready && bus.op_ready), 0);
      check("inv_cmd_ready_and_res", int'(bus.cmd_ready && bus.res_valid), 0);
      check("inv_op_ready_and_res", int'(bus.op_ready && bus.res_valid), 0);
    end
  end

  // ---------------- driver tasks (start and end on a falling edge) ----------------
  task automatic send_cmd(input int len);
    int w = 0;
    while (!bus.cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("cmd_ready_wait", int'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = LW'(len);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("busy_after_cmd", int'(bus.busy), 1);
    check("cmd_ready_after_cmd", int'(bus.cmd_ready), 0);
    check("mac_en_after_cmd", int'(bus.mac_en), 0);
    if (len != 0) begin
      check("mac_clr_pulse", int'(bus.mac_clr), 1);
      check("op_ready_load", int'(bus.op_ready), 1);
      check("res_valid_load", int'(bus.res_valid), 0);
    end else begin
      check("zero_len_res_valid", int'(bus.res_valid), 1);
      check("zero_len_res_data", int'(bus.res_data), 0);
      check("zero_len_no_clr", int'(bus.mac_clr), 0);
      check("zero_len_op_ready", int'(bus.op_ready), 0);
    end
  endtask

  // gap: 0 back-to-back, 1 op_valid toggling, 2 random gaps.
  task automatic feed_ops(input int len, input int gap);
    int   i = 0;
    int   cyc = 0;
    logic v;
    logic tog = 1'b1;
    while (i < len && cyc < 200) begin
      check("op_ready_load", int'(bus.op_ready), 1);
      case (gap)
        0:       v = 1'b1;
        1:       begin v = tog; tog = ~tog; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.op_valid = v;
      bus.op_a     = v ? pa[i] : DW'($urandom);
      bus.op_b     = v ? pb[i] : DW'($urandom);
      @(negedge clk);
      cyc++;
      check("mac_clr_once", int'(bus.mac_clr), 0);
      check("mac_en", int'(bus.mac_en), int'(v));
      if (v) begin
        check("mac_a", int'(bus.mac_a), int'(pa[i]));
        check("mac_b", int'(bus.mac_b), int'(pb[i]));
        i++;
      end
    end
    bus.op_valid = 1'b0;
    check("feed_done", i, len);
  endtask

  // Entered one cycle into DRAIN; stray operands are offered and must be ignored.
  task automatic wait_result();
    int lat = 1;
    while (!bus.res_valid && lat < 40) begin
      check("op_ready_drain", int'(bus.op_ready), 0);
      check("cmd_ready_drain", int'(bus.cmd_ready), 0);
      bus.op_valid = 1'($urandom_range(0, 1));
      bus.op_a     = DW'($urandom);
      bus.op_b     = DW'($urandom);
      @(negedge clk);
      lat++;
      check("mac_en_drain", int'(bus.mac_en), 0);
    end
    bus.op_valid = 1'b0;
    check("res_valid_seen", int'(bus.res_valid), 1);
    check("drain_latency", lat, LAT + 2);
  endtask

  task automatic take_result(input int exp, input int hold, input bit noise);
    for (int k = 0; k < hold; k++) begin
      check("res_valid_hold", int'(bus.res_valid), 1);
      check("res_data_hold", int'(bus.res_data), exp);
      check("cmd_ready_done", int'(bus.cmd_ready), 0);
      check("op_ready_done", int'(bus.op_ready), 0);
      bus.res_ready = 1'b0;
      bus.cmd_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.cmd_len   = LW'($urandom);
      @(negedge clk);
    end
    check("res_valid", int'(bus.res_valid), 1);
    check("res_data", int'(bus.res_data), exp);
    bus.res_ready = 1'b1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("res_valid_cleared", int'(bus.res_valid), 0);
    check("cmd_ready_idle", int'(bus.cmd_ready), 1);
    check("busy_idle", int'(bus.busy), 0);
  endtask

  // Runs one command over pa/pb; expected result comes from exp_q.
  task automatic run_pairs(input int len, input int gap, input int hold);
    int e0;
    int c0;
    logic [AW-1:0] exp;
    e0 = en_cnt;
    c0 = clr_cnt;
    send_cmd(len);
    if (len != 0) begin
      feed_ops(len, gap);
      wait_result();
    end
    exp = exp_q.pop_front();
    take_result(int'(exp), hold, 1'b1);
    check("mac_en_count", en_cnt - e0, len);
    check("mac_clr_count", clr_cnt - c0, (len != 0) ? 1 : 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, int'(bus.cmd_ready), 1);
    check({tag, "_op_ready"}, int'(bus.op_ready), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_mac_clr"}, int'(bus.mac_clr), 0);
    check({tag, "_mac_en"}, int'(bus.mac_en), 0);
    check({tag, "_mac_a"}, int'(bus.mac_a), 0);
    check({tag, "_mac_b"}, int'(bus.mac_b), 0);
    check({tag, "_res_valid"}, int'(bus.res_valid), 0);
    check({tag, "_res_data"}, int'(bus.res_data), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int len;
    int a0;
    int b0;
    int step;
    int gap;
    int hold;
    int exp_res;
  } vec_t;

  vec_t vecs[6];

  // ---------------- main sequence ----------------
  initial begin
    int e0;
    int c0;
    int sum;
    int len;

    vecs[0] = '{3, 2, 3, 2, 0, 2, 68};
    vecs[1] = '{0, 0, 0, 0, 0, 1, 0};
    vecs[2] = '{15, 255, 255, 0, 1, 3, 975375};
    vecs[3] = '{1, 9, 9, 0, 0, 0, 81};
    vecs[4] = '{2, 10, 20, 1, 1, 1, 431};
    vecs[5] = '{4, 0, 7, 1, 2, 0, 56};

    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.op_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    @(negedge clk);

    // Table-driven commands.
    for (int v = 0; v < 6; v++) begin
      pa.delete();
      pb.delete();
      for (int i = 0; i < vecs[v].len; i++) begin
        pa.push_back(DW'(vecs[v].a0 + i * vecs[v].step));
        pb.push_back(DW'(vecs[v].b0 + i * vecs[v].step));
      end
      exp_q.push_back(AW'(vecs[v].exp_res));
      run_pairs(vecs[v].len, vecs[v].gap, vecs[v].hold);
    end

    // Result held 10 cycles with a command waiting; it is taken only in IDLE.
    e0 = en_cnt;
    c0 = clr_cnt;
    pa = '{8'd1, 8'd3};
    pb = '{8'd2, 8'd4};
    send_cmd(2);
    feed_ops(2, 0);
    wait_result();
    for (int k = 0; k < 10; k++) begin
      check("wait_res_valid", int'(bus.res_valid), 1);
      check("wait_res_data", int'(bus.res_data), 14);
      check("wait_cmd_ready", int'(bus.cmd_ready), 0);
      bus.cmd_valid = 1'b1;
      bus.cmd_len   = LW'(1);
      bus.res_ready = 1'b0;
      @(negedge clk);
      check("wait_busy", int'(bus.busy), 1);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("handshake_idle_busy", int'(bus.busy), 0);
    check("handshake_idle_cmd_ready", int'(bus.cmd_ready), 1);
    check("handshake_idle_no_clr", int'(bus.mac_clr), 0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("late_accept_busy", int'(bus.busy), 1);
    check("late_accept_clr", int'(bus.mac_clr), 1);
    check("late_accept_op_ready", int'(bus.op_ready), 1);
    pa = '{8'd5};
    pb = '{8'd6};
    feed_ops(1, 0);
    wait_result();
    take_result(30, 0, 1'b0);
    check("wait_seq_en_count", en_cnt - e0, 3);
    check("wait_seq_clr_count", clr_cnt - c0, 2);

    // Reset in the middle of a 4-pair command.
    pa = '{8'd1, 8'd2, 8'd3, 8'd4};
    pb = '{8'd1, 8'd2, 8'd3, 8'd4};
    send_cmd(4);
    feed_ops(2, 0);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pa = '{8'd9};
    pb = '{8'd9};
    exp_q.push_back(AW'(81));
    run_pairs(1, 0, 1);

    // Random commands against the dot-product reference.
    for (int r = 0; r < 40; r++) begin
      len = $urandom_range(0, 15);
      pa.delete();
      pb.delete();
      sum = 0;
      for (int i = 0; i < len; i++) begin
        pa.push_back(DW'($urandom));
        pb.push_back(DW'($urandom));
        sum += int'(pa[i]) * int'(pb[i]);
      end
      exp_q.push_back(AW'(sum));
      run_pairs(len, 2, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand width.
REQ-002 SHALL have parameter LEN_W, default 4, command length field width (max 15 pairs).
REQ-003 SHALL have parameter ACC_W, default 20, accumulator/result width (DATA_W*2+LEN_W).
REQ-004 SHALL have parameter MAC_LAT, default 2, cycles from mac_en to mac_acc updated by datapath.
REQ-005 SHALL have port clk  in  1  single clock, rising edge; all logic in this one domain.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_len in LEN_W: start a dot-product of cmd_len operand pairs.
REQ-008 SHALL have ports op_valid in 1, op_ready out 1, op_a in DATA_W, op_b in DATA_W: operand pair stream.
REQ-009 SHALL have ports mac_clr out 1, mac_en out 1, mac_a out DATA_W, mac_b out DATA_W: drive to MAC datapath.
REQ-010 SHALL have port mac_acc in ACC_W: accumulator value returned by MAC datapath.
REQ-011 SHALL have ports res_valid out 1, res_ready in 1, res_data out ACC_W: result handshake.
REQ-012 SHALL have port busy out 1: high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, DRAIN, DONE.
REQ-014 IDLE: cmd_ready=1, all other handshake outputs 0; on cmd_valid SHALL latch cmd_len into remaining-count.
REQ-015 IDLE accept, cmd_len!=0 -> LOAD; mac_clr SHALL be high for exactly the one cycle after acceptance.
REQ-016 IDLE accept, cmd_len==0 -> DONE directly, res_data=0, no mac_clr/mac_en pulse.
REQ-017 LOAD: op_ready=1; each op_valid&&op_ready SHALL produce, next cycle, mac_en=1 with mac_a/mac_b = registered op_a/op_b; mac_en=0 otherwise.
REQ-018 LOAD: remaining-count SHALL decrement per accepted pair; on acceptance of last pair -> DRAIN.
REQ-019 Back-to-back pairs (op_valid held high) SHALL be accepted one per cycle, no bubbles; op_valid gaps SHALL only stall, never drop or duplicate a pair.
REQ-020 DRAIN: SHALL wait MAC_LAT+1 cycles after entry, then capture mac_acc into res_data and -> DONE.
REQ-021 DONE: res_valid=1, res_data held stable until res_valid&&res_ready, then -> IDLE.
REQ-022 cmd_ready SHALL be 0 outside IDLE; commands presented while busy SHALL be ignored (not latched).
REQ-023 op_ready SHALL be 0 outside LOAD; operands presented outside LOAD SHALL be ignored.
REQ-024 Result handshake and a waiting cmd_valid in the same cycle: command SHALL be accepted no earlier than the following cycle (first IDLE cycle).
REQ-025 mac_clr and mac_en SHALL never be high in the same cycle; mac_clr precedes first mac_en by >=1 cycle.
REQ-026 All outputs SHALL be registered except cmd_ready, op_ready, busy (decoded from state register only, no input-to-output combinational path).

Reset
REQ-027 rst high SHALL asynchronously force IDLE, counters 0, mac_clr/mac_en/res_valid 0, mac_a/mac_b/res_data 0, at any point including mid-LOAD or DRAIN.
REQ-028 First command after reset release SHALL behave identically to a command from power-up.

Structure
REQ-029 Shared package mac_pkg SHALL hold FSM state enum type, DATA_W/LEN_W/ACC_W defaults and MAC_LAT.
REQ-030 Single sub-module mac_drain_timer (load/count-down of MAC_LAT+1, done pulse) SHALL be used for DRAIN; everything else flat.

Verification
REQ-031 cmd_len=3, pairs (2,3),(4,5),(6,7) back-to-back, reference MAC model -> mac_clr 1 cycle, 3 consecutive mac_en, res_data=68, res_valid until res_ready.
REQ-032 cmd_len=0 -> DONE next cycle, res_data=0, mac_clr/mac_en never asserted.
REQ-033 cmd_len=15, all pairs (255,255), op_valid toggled every other cycle -> exactly 15 mac_en pulses, res_data=975375.
REQ-034 res_ready held low 10 cycles in DONE -> res_data/res_valid stable; cmd_valid during wait not accepted; accepted cycle after handshake.
REQ-035 rst asserted after 2 of 4 pairs -> all outputs 0 same cycle; new cmd_len=1, pair (9,9) -> res_data=81.
REQ-036 Assertions throughout: no mac_clr&&mac_en, cmd_ready only in IDLE, op_ready only in LOAD, mac_en count == cmd_len per command.
